seg7_scan_ctrl: RTL and testbench
=================================

// Module: seg7_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for a multi-digit 7-segment display.
//  Shares one bcd7seg decoder among NUM_DIGITS digits.
//  - Steps through the digits one at a time and drives the selected digit's BCD code
//    and active-low anode.
//  - Inserts a blank guard between digits to stop ghosting.
//  - Loads new display values through a valid/ready handshake; commits them only at
//    frame boundaries, so a frame never shows a mix of old and new digits.
// PARAMETERS
//  NUM_DIGITS    4       number of digits scanned (>=2)
//  DWELL_CYCLES  50000   clk cycles each digit is lit (>=1)
//  GUARD_CYCLES  500     clk cycles with all anodes off before each digit (>=1)
// PORTS
//  clk        in   1              system clock, rising edge
//  rst        in   1              synchronous, active-high reset
//  en         in   1              scan enable; low = display dark
//  wr_valid   in   1              new display value offered
//  wr_data    in   4*NUM_DIGITS   BCD digits; [3:0] = digit 0 (rightmost)
//  wr_ready   out  1              controller can accept wr_data
//  bcd_out    out  4              BCD code to the shared bcd7seg decoder
//  an         out  NUM_DIGITS     anodes, active-low; an[i] lights digit i
//  frame_done out  1              1-cycle pulse at end of digit NUM_DIGITS-1 ON phase
// BEHAVIOUR
//  Reset values
//   - an = all 1; bcd_out = 4'hF (decoder blanks); wr_ready = 1; frame_done = 0.
//   - state = GUARD, idx = 0, counter = 0, active = shadow = 0, pending = 0.
//  FSM states
//   - GUARD: an all 1; bcd_out = active digit idx. After GUARD_CYCLES cycles -> ON.
//   - ON: an[idx] = 0, all other anodes 1; bcd_out unchanged. After DWELL_CYCLES cycles -> GUARD.
//     On leaving ON, idx increments, wrapping NUM_DIGITS-1 -> 0.
//  Frame
//   - Frame length = NUM_DIGITS*(GUARD_CYCLES+DWELL_CYCLES) cycles.
//   - On the last ON cycle of idx NUM_DIGITS-1: frame_done = 1 for that cycle.
//   - In that same cycle, if pending = 1: active <= shadow, pending <= 0.
//  Handshake
//   - Transfer occurs when wr_valid & wr_ready on a clock edge: shadow <= wr_data, pending <= 1.
//   - wr_ready = !pending: it drops the cycle after a transfer and rises the cycle after commit.
//   - A transfer in the same cycle as a frame boundary does not commit in that cycle.
//     It commits at the next boundary (commit samples the pre-edge pending).
//   - Latency from transfer to first lit new digit: <= 1 frame + GUARD_CYCLES + 1.
//   - wr_data is sampled only on a transfer; its value is don't-care otherwise.
//  Enable
//   - en = 0 (synchronous): the next edge forces state = GUARD, idx = 0, counter = 0,
//     an = all 1, frame_done = 0.
//   - The handshake keeps working; a pending value commits at the first boundary after
//     en returns to 1.
//  Other rules
//   - Digit codes above 9 pass through unchanged; the decoder blanks them.
//   - Counter width = $clog2(max(DWELL_CYCLES, GUARD_CYCLES)+1); no overflow is possible.
//   - Reset mid-frame: all state returns to reset values on the same edge; shadow and
//     pending are lost.
// CONFIGURATION
//  SEG7_LZ_BLANK_EN
//   - Defined: leading-zero blanking. For idx != 0, if active digits idx..NUM_DIGITS-1
//     are all 4'h0, then bcd_out = 4'hF during that digit's GUARD and ON phases.
//     Anode timing is unchanged.
//   - Undefined: every digit is shown literally; 4'h0 displays as 0.
// STRUCTURE
//  - Package seg7_pkg holds:
//    - typedef enum logic {GUARD, ON} scan_state_t
//    - localparam logic [3:0] BCD_BLANK = 4'hF
//  - No sub-module needed. The bcd7seg decoder is instantiated by the parent, not inside
//    this block.
// TESTING  (NUM_DIGITS=4, DWELL_CYCLES=8, GUARD_CYCLES=2 unless noted)
//  1. Reset
//     - Stimulus: rst held 3 cycles, then released; en = 1.
//     - Response: an = 4'hF and bcd_out = 4'hF during reset.
//     - Response: first an = 4'b1110 on cycle 3 after release; frame_done first fires at cycle 40.
//  2. Write then commit
//     - Stimulus: write 16'h1234 at cycle 5.
//     - Response: wr_ready = 0 from cycle 6.
//     - Response: after the next frame_done, bcd_out = 4 with an = 1110, then 3 with an = 1101,
//       and so on; wr_ready = 1 again after commit.
//  3. Back-pressure
//     - Stimulus: write 16'h1111, then hold wr_valid with 16'h2222 while pending.
//     - Response: no transfer until wr_ready = 1; the frame shows 1111, the next frame shows 2222.
//  4. Boundary collision
//     - Stimulus: transfer 16'h5678 in exactly the frame_done cycle.
//     - Response: the following frame still shows the old value; 5678 appears one frame later.
//  5. Enable drop
//     - Stimulus: en = 0 mid-ON of idx 2 for 5 cycles.
//     - Response: an = 4'hF the next cycle; after en = 1, the scan restarts at idx 0 with a GUARD phase.
//  6. Leading-zero blanking (SEG7_LZ_BLANK_EN)
//     - Stimulus: write 16'h0070.
//     - Response: bcd_out = 0, 7, F, F for idx 0..3.
//     - Response without the macro: bcd_out = 0, 7, 0, 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scan controller.
// Leading-zero blanking in seg7_scan_ctrl is enabled by SEG7_LZ_BLANK_EN.
package seg7_pkg;

  typedef enum logic {GUARD, ON} scan_state_t;

  localparam logic [3:0] BCD_BLANK = 4'hF;

endpackage

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed scan controller for a multi-digit 7-segment display.
// Define SEG7_LZ_BLANK_EN to blank leading zeros on digits above 0.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 50000,
  parameter int GUARD_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    wr_valid,
  input  logic [4*NUM_DIGITS-1:0] wr_data,
  output logic                    wr_ready,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int MAXC = (DWELL_CYCLES > GUARD_CYCLES) ?
                        DWELL_CYCLES : GUARD_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam int IW = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] G_LAST = CW'(GUARD_CYCLES - 1);
  localparam logic [CW-1:0] D_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);

  scan_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] idx, idx_n;

  logic [4*NUM_DIGITS-1:0] active, active_n, shadow;
  logic pending, xfer, commit;

  logic [NUM_DIGITS-1:0] an_n;
  logic [3:0] bcd_n;
  logic fd_n;

  assign wr_ready = !pending;
  assign xfer     = wr_valid && !pending;
  // frame_done is high exactly in the last ON cycle of the frame
  assign commit   = frame_done && pending;

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    idx_n   = idx;
    if (!en) begin
      state_n = GUARD;
      cnt_n   = '0;
      idx_n   = '0;
    end else begin
      unique case (state)
        GUARD: begin
          if (cnt == G_LAST) begin
            state_n = ON;
            cnt_n   = '0;
          end
        end
        ON: begin
          if (cnt == D_LAST) begin
            state_n = GUARD;
            cnt_n   = '0;
            idx_n   = (idx == I_LAST) ? '0 : idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are registered from the next-state values so they
  // line up with the state they describe.
  always_comb begin
    active_n = commit ? shadow : active;
    an_n     = '1;
    if (en && state_n == ON) an_n[idx_n] = 1'b0;
    fd_n  = en && state_n == ON && cnt_n == D_LAST &&
            idx_n == I_LAST;
    bcd_n = active_n[{idx_n, 2'b00} +: 4];
`ifdef SEG7_LZ_BLANK_EN
    begin
      logic lz;
      lz = (idx_n != '0);
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (i >= int'(idx_n) && active_n[4*i +: 4] != 4'h0)
          lz = 1'b0;
      end
      if (lz) bcd_n = BCD_BLANK;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= GUARD;
      cnt        <= '0;
      idx        <= '0;
      active     <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
      an         <= '1;
      bcd_out    <= BCD_BLANK;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      active     <= active_n;
      an         <= an_n;
      bcd_out    <= bcd_n;
      frame_done <= fd_n;
      if (commit) begin
        pending <= 1'b0;
      end else if (xfer) begin
        shadow  <= wr_data;
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Randomized bench for seg7_scan_ctrl against a frame-position model.
// Build with or without SEG7_LZ_BLANK_EN to match the DUT.
module tb_seg7_scan_ctrl;

  localparam int N     = 4;
  localparam int D     = 8;
  localparam int G     = 2;
  localparam int SLOT  = G + D;
  localparam int FRAME = N * SLOT;

  logic clk = 0;
  logic rst, en, wr_valid, wr_ready, frame_done;
  logic [4*N-1:0] wr_data;
  logic [3:0] bcd_out;
  logic [N-1:0] an;

  int checks = 0;
  int errors = 0;

  seg7_scan_ctrl #(
    .NUM_DIGITS(N), .DWELL_CYCLES(D), .GUARD_CYCLES(G)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .bcd_out(bcd_out), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: position within the frame plus the committed/pending values
  int t = 0;
  bit fresh = 1;
  bit m_ok = 0;
  logic [15:0] m_active = 0, m_shadow = 0;
  bit m_pending = 0;

  function automatic logic [3:0] exp_digit(logic [15:0] a, int d);
    logic [3:0] v;
    v = a[d*4 +: 4];
`ifdef SEG7_LZ_BLANK_EN
    if (d != 0 && (a >> (4*d)) == 16'h0) v = 4'hF;
`endif
    return v;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      t = 0; fresh = 1;
      m_active = 0; m_shadow = 0; m_pending = 0;
    end else begin
      if (t == FRAME-1 && m_pending) begin
        m_active = m_shadow; m_pending = 0;
      end else if (wr_valid && !m_pending) begin
        m_shadow = wr_data; m_pending = 1;
      end
      t = en ? (t + 1) % FRAME : 0;
      fresh = 0;
    end
    m_ok = 1;
  end

  always @(negedge clk) begin
    if (m_ok) begin
      int d, ph;
      logic [3:0] ea, eb;
      d  = t / SLOT;
      ph = t % SLOT;
      ea = 4'hF;
      if (ph >= G) ea[d] = 1'b0;
      eb = fresh ? 4'hF : exp_digit(m_active, d);
      chk("an", 32'(an), 32'(ea));
      chk("bcd_out", 32'(bcd_out), 32'(eb));
      chk("frame_done", 32'(frame_done), 32'(t == FRAME-1));
      chk("wr_ready", 32'(wr_ready), 32'(!m_pending));
    end
  end

  task automatic wait_ready(input string nm);
    int n = 0;
    while (!wr_ready && n < 300) begin @(negedge clk); n++; end
    chk(nm, 32'(wr_ready), 32'd1);
  endtask

  task automatic write(input logic [15:0] v);
    wait_ready("write_ready");
    wr_valid = 1; wr_data = v;
    @(negedge clk);
    wr_valid = 0;
  endtask

  task automatic show(input int i, output logic [3:0] v);
    logic [3:0] m;
    int n = 0;
    m = 4'b0001 << i;
    m = ~m;
    while (an !== m && n < 200) begin @(negedge clk); n++; end
    chk("show_an", 32'(an), 32'(m));
    v = bcd_out;
  endtask

  initial begin
    logic [3:0] v;
    int first_on, first_fd, n, low;
    rst = 1; en = 1; wr_valid = 0; wr_data = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_bcd", 32'(bcd_out), 32'hF);
    chk("rst_fd", 32'(frame_done), 32'h0);
    chk("rst_ready", 32'(wr_ready), 32'h1);
    @(posedge clk); #1 rst = 0;

    first_on = 0; first_fd = 0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (an == 4'b1110 && first_on == 0) first_on = c;
      if (frame_done && first_fd == 0) first_fd = c;
      if (c == 5) begin
        chk("ready_c5", 32'(wr_ready), 32'h1);
        wr_valid = 1; wr_data = 16'h1234;
      end
      if (c == 6) begin
        wr_valid = 0;
        chk("ready_c6", 32'(wr_ready), 32'h0);
      end
      if (c == 41) chk("ready_c41", 32'(wr_ready), 32'h1);
      if (c == 43) begin
        chk("an_c43", 32'(an), 32'hE);
        chk("bcd_c43", 32'(bcd_out), 32'h4);
      end
    end
    chk("first_on_cycle", 32'(first_on), 32'd3);
    chk("first_fd_cycle", 32'(first_fd), 32'd40);
    show(1, v); chk("digit1_1234", 32'(v), 32'h3);

    // Back-pressure: 2222 held until the 1111 commit frees the shadow
    write(16'h1111);
    wr_valid = 1; wr_data = 16'h2222;
    n = 0;
    while (!wr_ready && n < 300) begin @(negedge clk); n++; end
    chk("bp_ready", 32'(wr_ready), 32'h1);
    @(negedge clk);
    wr_valid = 0;
    show(0, v); chk("bp_first", 32'(v), 32'h1);
    wait_ready("bp_commit");
    show(0, v); chk("bp_second", 32'(v), 32'h2);

    // Transfer in the frame_done cycle commits one frame later
    n = 0;
    while (!frame_done && n < 100) begin @(negedge clk); n++; end
    chk("coll_fd", 32'(frame_done), 32'h1);
    wr_valid = 1; wr_data = 16'h5678;
    @(negedge clk);
    wr_valid = 0;
    show(0, v); chk("coll_old", 32'(v), 32'h2);
    chk("coll_pending", 32'(wr_ready), 32'h0);
    wait_ready("coll_commit");
    show(0, v); chk("coll_new", 32'(v), 32'h8);

    // Enable drop in the middle of digit 2
    show(2, v);
    @(negedge clk);
    en = 0;
    @(negedge clk);
    chk("en_an", 32'(an), 32'hF);
    chk("en_fd", 32'(frame_done), 32'h0);
    repeat (3) @(negedge clk);
    en = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (an == 4'hF && n < 50);
    chk("en_restart_dly", 32'(n), 32'd2);
    chk("en_restart_an", 32'(an), 32'hE);

    // Leading zeros
    write(16'h0070);
    wait_ready("lz_commit");
    show(0, v); chk("lz_d0", 32'(v), 32'h0);
    show(1, v); chk("lz_d1", 32'(v), 32'h7);
`ifdef SEG7_LZ_BLANK_EN
    show(2, v); chk("lz_d2", 32'(v), 32'hF);
    show(3, v); chk("lz_d3", 32'(v), 32'hF);
`else
    show(2, v); chk("lz_d2", 32'(v), 32'h0);
    show(3, v); chk("lz_d3", 32'(v), 32'h0);
`endif

    // Random traffic, enable drops and one mid-frame reset
    low = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      wr_valid = ($urandom_range(0, 2) == 0);
      wr_data = 16'($urandom);
      case ($urandom_range(0, 3))
        1: wr_data &= 16'h00FF;
        2: wr_data &= 16'h000F;
        3: wr_data = 16'h0;
        default: ;
      endcase
      if (low > 0) begin
        low--;
        en = (low == 0);
      end else if ($urandom_range(0, 99) == 0) begin
        low = $urandom_range(1, 6);
        en = 0;
      end
      rst = (c == 1500 || c == 1501);
    end
    @(negedge clk);
    wr_valid = 0; en = 1; rst = 0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
